bar_collision_scorer: RTL and testbench
=======================================

# bar_collision_scorer

Game-state controller directly downstream of the bar environment. Each frame it snapshots the eight bar positions/openings and the bird position, scans the bars serially for a collision, counts bars passed, and decides run / crash / level-complete. It drives `pause` and `level` back into the environment, so it also closes the upstream loop.

## Interface
Parameters:
- `BAR_X0`, 80, x of left edge of bar slot 0
- `BAR_PITCH`, 80, x spacing between slots; slot k left edge xk = BAR_X0 + k*BAR_PITCH
- `BAR_W`, 20, bar width in pixels
- `BIRD_W`, 16, bird width
- `BIRD_H`, 16, bird height
- `FINISH_X`, 620, bird_x at/after which the level is complete
- `SCREEN_H`, 480, floor y
- `BAR_MASK`, 8'b0111_1110, bit k = 1 means slot k is checked and counted

Ports:
- `clkenv`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: begin/resume play
- `frame`  in  1  one-cycle strobe: evaluate current frame
- `bird_x`  in  10  bird left edge
- `bird_y`  in  10  bird top edge
- `bar_pos_bus`  in  80  slot k top-of-opening at [10k+9:10k], unsigned
- `bar_op_bus`  in  80  slot k opening height at [10k+9:10k], unsigned
- `pause`  out  1  freeze environment
- `level`  out  10  current level to environment
- `crash`  out  1  collision latched
- `score`  out  4  masked bars passed at last evaluation
- `busy`  out  1  scan in progress

## Operation
- States: IDLE, RUN, SCAN, EVAL, DEAD, WIN.
- IDLE: pause=1. `start` -> RUN.
- RUN: pause=0. `frame` -> SCAN; same edge snapshots both buses, bird_x, bird_y; k=0, hit=0, passed=0.
- SCAN: one slot per cycle, k=0..7, using snapshot only. For masked slot k (12-bit unsigned math, no wrap):
  - h-overlap: bird_x+BIRD_W > xk and bird_x < xk+BAR_W
  - v-miss: bird_y < pos_k or bird_y+BIRD_H > pos_k+op_k (opening extending past SCREEN_H is not clipped)
  - hit |= h-overlap & v-miss; passed += (xk+BAR_W <= bird_x)
  - unmasked slots contribute nothing. After k=7 -> EVAL.
- EVAL: floor = bird_y+BIRD_H > SCREEN_H. score <= passed.
  - hit|floor -> DEAD, crash=1.
  - else bird_x >= FINISH_X -> WIN, level <= level+1 (saturates at 1023).
  - else -> RUN.
- DEAD: pause=1, crash=1. `start` -> RUN, crash<=0, score<=0, level kept.
- WIN: pause=1. `start` -> RUN, score<=0.
- Priority: crash beats finish in the same EVAL.
- `frame` outside RUN ignored (dropped, not queued). `start` in RUN/SCAN/EVAL ignored. `start`&`frame` together in IDLE/DEAD/WIN: start taken, frame dropped.
- busy=1 exactly in SCAN and EVAL.

## Timing
- Reset (async, any state incl. mid-scan): state=IDLE, pause=1, level=1, crash=0, score=0, busy=0, counters cleared.
- All outputs registered.
- `frame` sampled at edge t -> busy high t+1..t+9 (8 SCAN + 1 EVAL) -> score/crash/level/pause updated, state RUN/DEAD/WIN visible at t+10.
- `start` at edge t -> pause low at t+1.
- Back-to-back: next `frame` accepted at t+10 earliest.

## Test plan
- Reset: assert rst_n=0 mid-SCAN -> immediately state IDLE, pause=1, level=1, crash=0, score=0, busy=0.
- Clean pass: start; slot2 pos=240 op=60; bird_x=250, bird_y=250; frame -> at +10 crash=0, score=1 (slot1 passed), pause=0, busy low.
- Hit: slot1 pos=240 op=60; bird_x=150, bird_y=100; frame -> at +10 crash=1, pause=1; further frames ignored; start -> crash=0, score=0, pause=0, level unchanged.
- Mask: bird_x=80, bird_y=0, slot0 opening excludes bird -> no crash (slot0 masked); same with bird_y=470 -> crash (floor).
- Finish: level=1, bird_x=620, bird_y in all openings -> at +10 level=2, score=6, pause=1; start -> pause=0, level=2; level 1023 finish stays 1023.
- Dropped strobe: frame at t and t+3 -> single evaluation, busy low at t+10, no second scan.

Source files
------------

// File: rtl/bar_collision_scorer.sv
// bar_collision_scorer: snapshots bars and bird each frame, scans the eight slots serially,
// and decides run / crash / level-complete, driving pause and level back to the environment.
module bar_collision_scorer #(
  parameter int         BAR_X0    = 80,
  parameter int         BAR_PITCH = 80,
  parameter int         BAR_W     = 20,
  parameter int         BIRD_W    = 16,
  parameter int         BIRD_H    = 16,
  parameter int         FINISH_X  = 620,
  parameter int         SCREEN_H  = 480,
  parameter logic [7:0] BAR_MASK  = 8'b0111_1110
) (
  input  logic        clkenv,
  input  logic        rst_n,
  input  logic        start,
  input  logic        frame,
  input  logic [9:0]  bird_x,
  input  logic [9:0]  bird_y,
  input  logic [79:0] bar_pos_bus,
  input  logic [79:0] bar_op_bus,
  output logic        pause,
  output logic [9:0]  level,
  output logic        crash,
  output logic [3:0]  score,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, RUN, SCAN, EVAL, DEAD, WIN} state_t;
  state_t      r_state;
  logic [79:0] r_pos, r_op;
  logic [11:0] r_bx, r_by;
  logic [2:0]  r_k;
  logic        r_hit;
  logic [3:0]  r_passed;
  logic [11:0] w_xk, w_pos, w_op;
  logic        w_chk, w_ovl, w_miss, w_pass, w_floor;
  // 12-bit geometry keeps every sum below 4096, so comparisons never wrap
  always_comb begin
    w_xk    = 12'(BAR_X0 + BAR_PITCH * int'(r_k));
    w_pos   = {2'b00, r_pos[10*r_k +: 10]};
    w_op    = {2'b00, r_op[10*r_k +: 10]};
    w_chk   = BAR_MASK[r_k];
    w_ovl   = (r_bx + 12'(BIRD_W) > w_xk) && (r_bx < w_xk + 12'(BAR_W));
    w_miss  = (r_by < w_pos) || (r_by + 12'(BIRD_H) > w_pos + w_op);
    w_pass  = w_xk + 12'(BAR_W) <= r_bx;
    w_floor = r_by + 12'(BIRD_H) > 12'(SCREEN_H);
  end
  always_ff @(posedge clkenv or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pos    <= '0;
      r_op     <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_k      <= '0;
      r_hit    <= 1'b0;
      r_passed <= '0;
      pause    <= 1'b1;
      level    <= 10'd1;
      crash    <= 1'b0;
      score    <= '0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          pause   <= 1'b0;
        end
        RUN: if (frame) begin
          r_state  <= SCAN;
          busy     <= 1'b1;
          r_pos    <= bar_pos_bus;
          r_op     <= bar_op_bus;
          r_bx     <= {2'b00, bird_x};
          r_by     <= {2'b00, bird_y};
          r_k      <= '0;
          r_hit    <= 1'b0;
          r_passed <= '0;
        end
        SCAN: begin
          r_hit    <= r_hit | (w_chk & w_ovl & w_miss);
          r_passed <= r_passed + 4'(w_chk & w_pass);
          r_k      <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= EVAL;
        end
        EVAL: begin
          busy  <= 1'b0;
          score <= r_passed;
          if (r_hit || w_floor) begin
            r_state <= DEAD;
            crash   <= 1'b1;
            pause   <= 1'b1;
          end else if (r_bx >= 12'(FINISH_X)) begin
            r_state <= WIN;
            pause   <= 1'b1;
            level   <= (level == 10'h3ff) ? level : level + 10'd1;
          end else begin
            r_state <= RUN;
          end
        end
        DEAD: if (start) begin
          r_state <= RUN;
          crash   <= 1'b0;
          score   <= '0;
          pause   <= 1'b0;
        end
        WIN: if (start) begin
          r_state <= RUN;
          score   <= '0;
          pause   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bar_collision_scorer.sv
// tb_bar_collision_scorer: table vectors, hand-written corner sequences and random frames
// checked against a slot-by-slot geometric reference model of the game rules.
module tb_bar_collision_scorer;
  logic        clkenv = 1'b0, rst_n = 1'b1, start = 1'b0, frame = 1'b0;
  logic [9:0]  bird_x = '0, bird_y = '0;
  logic [79:0] bar_pos_bus = '0, bar_op_bus = '0;
  logic        pause, crash, busy;
  logic [9:0]  level;
  logic [3:0]  score;
  int tests = 0, fails = 0;
  int m_state, m_level, m_score;
  bit m_crash, m_pause;
  localparam logic [7:0] MASK = 8'b0111_1110;

  typedef struct {
    int          bx;
    int          by;
    logic [79:0] pb;
    logic [79:0] ob;
    bit          crash;
    int          score;
    bit          win;
  } vec_t;
  vec_t tv[14];

  bar_collision_scorer dut (
    .clkenv(clkenv), .rst_n(rst_n), .start(start), .frame(frame),
    .bird_x(bird_x), .bird_y(bird_y), .bar_pos_bus(bar_pos_bus), .bar_op_bus(bar_op_bus),
    .pause(pause), .level(level), .crash(crash), .score(score), .busy(busy)
  );

  always #5 clkenv = ~clkenv;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".pause"}, int'(pause), int'(m_pause));
    chk({tag, ".crash"}, int'(crash), int'(m_crash));
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".level"}, int'(level), m_level);
    chk({tag, ".busy"},  int'(busy),  0);
  endtask

  function automatic logic [79:0] one(input int k, input int v);
    logic [79:0] b;
    b = '0;
    b[10*k +: 10] = 10'(v);
    return b;
  endfunction

  function automatic logic [79:0] rep(input int v);
    return {8{10'(v)}};
  endfunction

  // Reference: each masked slot tested independently with plain integer geometry
  function automatic void model_eval(input int bx, input int by, input logic [79:0] pb,
                                     input logic [79:0] ob, output bit hit, output int passed);
    hit = 0;
    passed = 0;
    for (int k = 0; k < 8; k++) begin
      int xk, p, o;
      xk = 80 + 80 * k;
      p  = int'(pb[10*k +: 10]);
      o  = int'(ob[10*k +: 10]);
      if (MASK[k]) begin
        if (bx + 16 > xk && bx < xk + 20 && (by < p || by + 16 > p + o)) hit = 1;
        if (xk + 20 <= bx) passed++;
      end
    end
  endfunction

  function automatic void model_frame(input int bx, input int by, input logic [79:0] pb,
                                      input logic [79:0] ob);
    bit hit;
    int passed;
    model_eval(bx, by, pb, ob, hit, passed);
    m_score = passed;
    if (hit || by + 16 > 480) begin
      m_state = 2; m_crash = 1; m_pause = 1;
    end else if (bx >= 620) begin
      m_state = 3; m_pause = 1;
      if (m_level < 1023) m_level++;
    end
  endfunction

  task automatic do_start(input string tag);
    @(negedge clkenv) start = 1'b1;
    @(negedge clkenv) start = 1'b0;
    if (m_state != 1) begin
      if (m_state == 2) begin m_crash = 0; m_score = 0; end
      if (m_state == 3) m_score = 0;
      m_state = 1;
      m_pause = 0;
    end
    chk_outs(tag);
  endtask

  task automatic ensure_run();
    if (m_state != 1) do_start("start");
  endtask

  task automatic drive(input int bx, input int by, input logic [79:0] pb, input logic [79:0] ob);
    bird_x = 10'(bx); bird_y = 10'(by); bar_pos_bus = pb; bar_op_bus = ob;
  endtask

  task automatic scramble();
    bird_x = 10'($urandom); bird_y = 10'($urandom);
    bar_pos_bus = {$urandom, $urandom, $urandom}; bar_op_bus = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_frame(input string tag, input int bx, input int by,
                          input logic [79:0] pb, input logic [79:0] ob);
    int n;
    @(negedge clkenv);
    drive(bx, by, pb, ob);
    frame = 1'b1;
    @(negedge clkenv);
    frame = 1'b0;
    scramble();
    n = 0;
    while (busy && n < 30) begin n++; @(negedge clkenv); end
    if (m_state == 1) begin
      chk({tag, ".busy_cycles"}, n, 9);
      model_frame(bx, by, pb, ob);
    end else begin
      chk({tag, ".ignored_busy"}, n, 0);
    end
    chk_outs(tag);
  endtask

  initial begin
    int n, hi;
    tv[0]  = '{250, 250, one(2, 240), one(2, 60),  0, 1, 0};
    tv[1]  = '{150, 100, one(1, 240), one(1, 60),  1, 0, 0};
    tv[2]  = '{80,  0,   one(0, 200), one(0, 50),  0, 0, 0};
    tv[3]  = '{80,  470, one(0, 200), one(0, 50),  1, 0, 0};
    tv[4]  = '{620, 250, rep(240),    rep(60),     0, 6, 1};
    tv[5]  = '{144, 100, rep(0),      rep(0),      0, 0, 0};
    tv[6]  = '{145, 100, rep(0),      rep(0),      1, 0, 0};
    tv[7]  = '{180, 100, rep(0),      rep(0),      0, 1, 0};
    tv[8]  = '{160, 100, one(1, 100), one(1, 16),  0, 0, 0};
    tv[9]  = '{160, 101, one(1, 100), one(1, 16),  1, 0, 0};
    tv[10] = '{160, 99,  one(1, 100), one(1, 16),  1, 0, 0};
    tv[11] = '{160, 464, one(1, 450), one(1, 100), 0, 0, 0};
    tv[12] = '{179, 100, rep(0),      rep(0),      1, 0, 0};
    tv[13] = '{619, 250, rep(240),    rep(60),     0, 6, 0};
    m_state = 0; m_level = 1; m_score = 0; m_crash = 0; m_pause = 1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clkenv);
    chk_outs("reset");
    rst_n = 1'b1;
    @(negedge clkenv);
    chk_outs("idle");
    do_frame("idle_frame", 250, 250, one(2, 240), one(2, 60));

    for (int i = 0; i < 14; i++) begin
      ensure_run();
      do_frame($sformatf("vec%0d", i), tv[i].bx, tv[i].by, tv[i].pb, tv[i].ob);
      chk($sformatf("vec%0d.crash_exp", i), int'(crash), int'(tv[i].crash));
      chk($sformatf("vec%0d.score_exp", i), int'(score), tv[i].score);
      chk($sformatf("vec%0d.pause_exp", i), int'(pause), int'(tv[i].crash | tv[i].win));
    end

    // crash, frames ignored while dead, then restart keeps level
    ensure_run();
    do_frame("hit", 150, 100, one(1, 240), one(1, 60));
    do_frame("dead_frame", 250, 250, one(2, 240), one(2, 60));
    do_start("restart");
    do_start("start_in_run");
    do_frame("hit2", 150, 100, one(1, 240), one(1, 60));
    @(negedge clkenv);
    drive(250, 250, one(2, 240), one(2, 60));
    start = 1'b1; frame = 1'b1;
    @(negedge clkenv);
    start = 1'b0; frame = 1'b0;
    m_state = 1; m_crash = 0; m_score = 0; m_pause = 0;
    chk_outs("start_and_frame");
    @(negedge clkenv);
    chk("start_and_frame.no_scan", int'(busy), 0);

    // second strobe mid-scan is dropped, not queued
    @(negedge clkenv);
    drive(250, 250, one(2, 240), one(2, 60));
    frame = 1'b1;
    @(negedge clkenv);
    frame = 1'b0;
    repeat (2) @(negedge clkenv);
    frame = 1'b1; start = 1'b1;
    @(negedge clkenv);
    frame = 1'b0; start = 1'b0;
    n = 0;
    while (busy && n < 30) begin n++; @(negedge clkenv); end
    chk("dropped.busy_rest", n, 6);
    model_frame(250, 250, one(2, 240), one(2, 60));
    chk_outs("dropped");
    hi = 0;
    repeat (5) begin @(negedge clkenv); if (busy) hi++; end
    chk("dropped.no_second_scan", hi, 0);

    // async reset in the middle of a scan
    ensure_run();
    @(negedge clkenv);
    drive(150, 100, one(1, 240), one(1, 60));
    frame = 1'b1;
    @(negedge clkenv);
    frame = 1'b0;
    repeat (3) @(negedge clkenv);
    chk("midscan.busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    m_state = 0; m_level = 1; m_score = 0; m_crash = 0; m_pause = 1;
    chk_outs("midscan_reset");
    @(negedge clkenv) rst_n = 1'b1;
    repeat (2) @(negedge clkenv);
    chk_outs("after_reset");

    for (int i = 0; i < 150; i++) begin
      int bx, by;
      logic [79:0] pb, ob;
      ensure_run();
      if ($urandom_range(0, 3) == 0) do_start("rand_start");
      bx = $urandom_range(0, 700);
      by = $urandom_range(0, 490);
      for (int k = 0; k < 8; k++) begin
        pb[10*k +: 10] = 10'($urandom_range(0, 430));
        ob[10*k +: 10] = 10'($urandom_range(16, 140));
      end
      do_frame("rand", bx, by, pb, ob);
    end

    // level saturation
    while (m_level < 1023) begin
      ensure_run();
      do_frame("climb", 620, 250, rep(240), rep(60));
    end
    ensure_run();
    do_frame("saturate", 620, 250, rep(240), rep(60));
    chk("saturate.level", int'(level), 1023);
    do_start("saturate_start");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
